// File: rtl/uart_rx_frame.sv
// UART receive framer: oversamples RX_IN at Prescale clocks per bit, majority-votes
// three mid-bit samples, and emits one registered result pulse per frame.
module uart_rx_frame #(
  parameter int Data_width     = 8,
  parameter int Prescale_width = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [Prescale_width-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [Data_width-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BitCntW = (Data_width > 1) ? $clog2(Data_width) : 1;
  localparam logic [Prescale_width-1:0] One = Prescale_width'(1);
  localparam logic [Prescale_width-1:0] Two = Prescale_width'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [Prescale_width-1:0] r_presc;
  logic [Prescale_width-1:0] r_edge_cnt;
  logic [BitCntW-1:0]        r_bit_cnt;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_par_fail;
  logic [2:0]                r_samples;
  logic [Data_width-1:0]     r_data;

  logic [Prescale_width-1:0] w_half;
  logic                      w_last_tick;
  logic                      w_result_tick;
  logic                      w_vote;
  logic                      w_last_bit;
  logic                      w_par_bad;
  logic                      w_frame_good;

  assign w_half        = r_presc >> 1;
  assign w_last_tick   = (r_edge_cnt == r_presc - One);
  // Outputs are loaded one tick early so the registered pulse lands on edge_cnt = P-1.
  assign w_result_tick = (r_edge_cnt == r_presc - Two);
  assign w_vote        = (r_samples[0] & r_samples[1]) |
                         (r_samples[0] & r_samples[2]) |
                         (r_samples[1] & r_samples[2]);
  assign w_last_bit    = (r_bit_cnt == BitCntW'(Data_width - 1));
  assign w_par_bad     = (w_vote != ((^r_data) ^ r_par_typ));
  assign w_frame_good  = w_vote & ~r_par_fail;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path drives w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (!RX_IN) w_next_state = S_START;
      S_START:  if (w_last_tick) w_next_state = w_vote ? S_IDLE : S_DATA;
      S_DATA:   if (w_last_tick && w_last_bit) w_next_state = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_last_tick) w_next_state = S_STOP;
      S_STOP:   if (w_last_tick) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc    <= '0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_samples  <= '0;
      r_data     <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (r_state == S_IDLE) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
        // The detect cycle is tick 0 of the start bit; frame settings freeze here.
        if (!RX_IN) begin
          r_edge_cnt <= One;
          r_presc    <= Prescale;
          r_par_en   <= PAR_EN;
          r_par_typ  <= PAR_TYP;
          r_par_fail <= 1'b0;
        end
      end else begin
        r_edge_cnt <= w_last_tick ? '0 : r_edge_cnt + One;
        if (r_edge_cnt == w_half - One) r_samples[0] <= RX_IN;
        if (r_edge_cnt == w_half)       r_samples[1] <= RX_IN;
        if (r_edge_cnt == w_half + One) r_samples[2] <= RX_IN;

        if (w_last_tick && r_state == S_DATA) begin
          r_data[r_bit_cnt] <= w_vote;
          r_bit_cnt         <= w_last_bit ? '0 : r_bit_cnt + BitCntW'(1);
        end

        if (w_last_tick && r_state == S_PARITY && w_par_bad) begin
          r_par_fail <= 1'b1;
        end

        if (w_result_tick && r_state == S_STOP) begin
          stp_err    <= ~w_vote;
          par_err    <= r_par_fail;
          data_valid <= w_frame_good;
          if (w_frame_good) P_DATA <= r_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table vectors, hand-built corner sequences and
// randomized frames scored against a frame-level reference model.
module tb_uart_rx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_frame #(.Data_width(8), .Prescale_width(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } ev_t;

  typedef struct {
    int         p;
    bit         pen;
    bit         ptyp;
    logic [7:0] d;
    bit         pbit;
    bit         sbit;
    bit         noisy;
    int         exp_tick;
    bit         exp_dv;
    bit         exp_pe;
    bit         exp_se;
    logic [7:0] exp_pd;
  } vec_t;

  ev_t        log_q[$];
  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_pdata;

  // Every cycle carrying any result pulse is logged with the cycle it appeared in.
  always @(negedge CLK) begin
    if (data_valid || par_err || stp_err)
      log_q.push_back(ev_t'{cyc, data_valid, par_err, stp_err, P_DATA});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_queues(input string tag);
    check({tag, " pulse count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d] cycle", tag, i),      log_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s[%0d] data_valid", tag, i), log_q[i].dv,  exp_q[i].dv);
      check($sformatf("%s[%0d] par_err", tag, i),    log_q[i].pe,  exp_q[i].pe);
      check($sformatf("%s[%0d] stp_err", tag, i),    log_q[i].se,  exp_q[i].se);
      check($sformatf("%s[%0d] P_DATA", tag, i),     log_q[i].pd,  exp_q[i].pd);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  // Frame-level reference: result depends only on what was sent, when it started, and prior P_DATA.
  function automatic ev_t model(input int sc, input int p, input bit pen, input bit ptyp,
                                input logic [7:0] d, input bit pbit, input bit sbit,
                                input logic [7:0] prev_pd);
    ev_t e;
    bit  pfail;
    pfail = pen && (pbit != ((^d) ^ ptyp));
    e.cyc = sc + (10 + int'(pen)) * p - 1;
    e.se  = !sbit;
    e.pe  = pfail;
    e.dv  = sbit && !pfail;
    e.pd  = e.dv ? d : prev_pd;
    return e;
  endfunction

  task automatic expect_frame(input int sc, input int p, input bit pen, input bit ptyp,
                              input logic [7:0] d, input bit pbit, input bit sbit);
    ev_t e;
    e = model(sc, p, pen, ptyp, d, pbit, sbit, exp_pdata);
    exp_q.push_back(e);
    exp_pdata = e.pd;
  endtask

  function automatic logic [5:0] rand_presc();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  task automatic tick_idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  task automatic drive_level(input bit v, input int n, output int first);
    first = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      if (i == 0) first = cyc;
      RX_IN = v;
    end
  endtask

  // Drives one frame; noisy flips one of the three mid-bit samples of every bit.
  task automatic drive_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                             input bit pbit, input bit sbit, input bit noisy,
                             input int stop_after, output int start_cyc);
    logic [10:0] bits;
    int          nb;
    int          bad;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pen) bits[9] = pbit;
    bits[9 + int'(pen)] = sbit;
    nb = 10 + int'(pen);
    start_cyc = -1;
    for (int i = 0; i < nb; i++) begin
      bad = noisy ? (p / 2 - 1 + int'($urandom_range(0, 2))) : -1;
      for (int k = 0; k < p; k++) begin
        if (i * p + k >= stop_after) return;
        @(posedge CLK); #1;
        if (i == 0 && k == 0) begin
          start_cyc = cyc;
          Prescale  = 6'(p);
          PAR_EN    = pen;
          PAR_TYP   = ptyp;
        end else if (i == 0 && k == 1) begin
          Prescale = rand_presc();
          PAR_EN   = 1'($urandom_range(0, 1));
          PAR_TYP  = 1'($urandom_range(0, 1));
        end
        RX_IN = (k == bad) ? ~bits[i] : bits[i];
      end
    end
  endtask

  vec_t tbl[5];

  initial begin
    int sc, sc2, c0, dummy;
    bit pen, ptyp, pbit, sbit;
    int p;
    logic [7:0] d;

    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset P_DATA", P_DATA, 8'h00);
    check("reset data_valid", data_valid, 1'b0);
    check("reset par_err", par_err, 1'b0);
    check("reset stp_err", stp_err, 1'b0);
    exp_pdata = 8'h00;

    tbl[0] = '{8,  1, 0, 8'hA5, 0, 1, 0,  87, 1, 0, 0, 8'hA5};
    tbl[1] = '{16, 1, 1, 8'h3C, 0, 1, 0, 175, 0, 1, 0, 8'hA5};
    tbl[2] = '{32, 0, 0, 8'hFF, 0, 0, 0, 319, 0, 0, 1, 8'hA5};
    tbl[3] = '{16, 0, 0, 8'h81, 0, 1, 1, 159, 1, 0, 0, 8'h81};
    tbl[4] = '{8,  1, 1, 8'h00, 1, 1, 0,  87, 1, 0, 0, 8'h00};

    for (int i = 0; i < 5; i++) begin
      drive_frame(tbl[i].p, tbl[i].pen, tbl[i].ptyp, tbl[i].d, tbl[i].pbit, tbl[i].sbit,
                  tbl[i].noisy, 1000, sc);
      tick_idle(4);
      exp_q.push_back(ev_t'{sc + tbl[i].exp_tick, tbl[i].exp_dv, tbl[i].exp_pe,
                            tbl[i].exp_se, tbl[i].exp_pd});
      compare_queues($sformatf("vec%0d", i));
      exp_pdata = tbl[i].exp_pd;
    end

    // Start glitch: two low cycles must not start a frame.
    @(posedge CLK); #1;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; RX_IN = 1'b0;
    @(posedge CLK); #1;
    RX_IN = 1'b0;
    tick_idle(20);
    compare_queues("glitch");
    drive_frame(8, 0, 0, 8'h5A, 0, 1, 0, 1000, sc);
    tick_idle(4);
    expect_frame(sc, 8, 0, 0, 8'h5A, 0, 1);
    compare_queues("after glitch");

    // Back-to-back frames with no idle gap.
    drive_frame(8, 1, 0, 8'h01, 1, 1, 0, 1000, sc);
    drive_frame(8, 1, 0, 8'h02, 1, 1, 0, 1000, sc2);
    tick_idle(4);
    if (log_q.size() >= 2) check("b2b spacing", log_q[1].cyc - log_q[0].cyc, 11 * 8);
    expect_frame(sc, 8, 1, 0, 8'h01, 1, 1);
    expect_frame(sc2, 8, 1, 0, 8'h02, 1, 1);
    compare_queues("b2b");

    // Break: line held low through a whole frame restarts detection immediately.
    @(posedge CLK); #1;
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    drive_level(1'b0, 88, c0);
    drive_level(1'b1, 72, dummy);
    tick_idle(4);
    expect_frame(c0, 8, 0, 0, 8'h00, 0, 0);
    expect_frame(c0 + 80, 8, 0, 0, 8'hFF, 0, 1);
    compare_queues("break");

    // Reset during data bit 4 aborts the frame silently.
    drive_frame(8, 0, 0, 8'hC3, 0, 1, 0, 42, sc);
    @(posedge CLK); #1;
    RST = 1'b1; RX_IN = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    tick_idle(120);
    @(negedge CLK);
    check("abort P_DATA", P_DATA, 8'h00);
    check("abort data_valid", data_valid, 1'b0);
    check("abort par_err", par_err, 1'b0);
    check("abort stp_err", stp_err, 1'b0);
    compare_queues("abort");
    exp_pdata = 8'h00;
    drive_frame(8, 0, 0, 8'hC3, 0, 1, 0, 1000, sc);
    tick_idle(4);
    expect_frame(sc, 8, 0, 0, 8'hC3, 0, 1);
    compare_queues("after reset");

    // Randomized frames with noise, random settings and random gaps.
    for (int n = 0; n < 24; n++) begin
      p    = int'(rand_presc());
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      pbit = ((^d) ^ ptyp) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 4) != 0);
      drive_frame(p, pen, ptyp, d, pbit, sbit, 1, 1000, sc);
      expect_frame(sc, p, pen, ptyp, d, pbit, sbit);
      tick_idle(int'($urandom_range(0, 2)));
    end
    tick_idle(4);
    compare_queues("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
